// File: rtl/pixel_stream_tx.sv
// Streams one frame from frame memory into a line buffer, raster order.
// Ports: clk/rst, start/stall in; mem_rd_en/mem_addr/mem_rd_data to memory;
// frame_start/shift/sr_in to line buffer; busy/done status.
// Optional: PIXEL_TX_LINE_GAP_EN adds LINE_GAP idle read cycles per row.
module pixel_stream_tx #(
  parameter int DSIZE = 8,
  parameter int IMAGE_WIDTH = 256,
  parameter int IMAGE_LENGTH = 256,
`ifdef PIXEL_TX_LINE_GAP_EN
  parameter int LINE_GAP = 4,
`endif
  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_LENGTH,
  localparam int ASIZE = $clog2(IMAGE_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             mem_rd_en,
  output logic [ASIZE-1:0] mem_addr,
  input  logic [DSIZE-1:0] mem_rd_data,
  output logic             frame_start,
  output logic             shift,
  output logic [DSIZE-1:0] sr_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    STREAM,
    TAIL,
    DONE
  } state_t;

  localparam logic [ASIZE-1:0] LAST = ASIZE'(IMAGE_SIZE - 1);

  state_t st;
  state_t nxt;

  logic [ASIZE-1:0] addr;
  logic             all_read;
  logic             shift_q;
  logic             gap_free;
  logic             last_rd;

  assign mem_addr = addr;
  assign last_rd  = (addr == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt         = st;
    frame_start = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    shift       = shift_q;
    sr_in       = shift_q ? mem_rd_data : '0;
    unique case (st)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = SOF;
      end
      SOF: begin
        frame_start = 1'b1;
        nxt = STREAM;
      end
      STREAM: begin
        mem_rd_en = !stall && !all_read && gap_free;
        // all_read first rises in the cycle the last pixel shifts out
        if (all_read && shift_q) nxt = TAIL;
      end
      TAIL: begin
        shift = 1'b1;
        sr_in = '0;
        nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // addr saturates at the last pixel so mem_addr holds a legal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      all_read <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      shift_q <= mem_rd_en;
      if (st == SOF) begin
        addr     <= '0;
        all_read <= 1'b0;
      end else if (mem_rd_en) begin
        if (last_rd) all_read <= 1'b1;
        else         addr <= addr + 1'b1;
      end
    end
  end

`ifdef PIXEL_TX_LINE_GAP_EN
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int GW = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

  logic [CW-1:0] col;
  logic [GW-1:0] gap;

  assign gap_free = (gap == '0);

  // gap counts down every cycle, stall or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      gap <= '0;
    end else if (st == SOF) begin
      col <= '0;
      gap <= '0;
    end else if (mem_rd_en) begin
      if (col == CW'(IMAGE_WIDTH - 1)) begin
        col <= '0;
        if (!last_rd) gap <= GW'(LINE_GAP);
      end else begin
        col <= col + 1'b1;
      end
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end
`else
  assign gap_free = 1'b1;
`endif

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx on a 4x3 frame, mem[i]=i+1.
// Pixel scoreboard filled per frame, popped on each shift.
module tb_pixel_stream_tx;

  localparam int W = 4;
  localparam int L = 3;
  localparam int N = W * L;
`ifdef PIXEL_TX_LINE_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif
  localparam int GX = 2 * GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rd_data = 8'd0;
  logic       frame_start;
  logic       shift;
  logic [7:0] sr_in;
  logic       busy;
  logic       done;

  int pass = 0;
  int total = 0;
  logic [7:0] q[$];
  int rd_k[N];

  pixel_stream_tx #(
    .DSIZE(8),
    .IMAGE_WIDTH(W),
`ifdef PIXEL_TX_LINE_GAP_EN
    .LINE_GAP(GAP),
`endif
    .IMAGE_LENGTH(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stall(stall),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .frame_start(frame_start),
    .shift(shift),
    .sr_in(sr_in),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= 8'(mem_addr) + 8'd1;

  task automatic run_frame(input string nm, input int slo,
                           input int shi, input int rk,
                           input int exp_done);
    int k;
    int exp_addr;
    int nfs;
    int nsh;
    int first_sh;
    bit seen;
    logic [7:0] ex;
    q.delete();
    for (int i = 1; i <= N; i++) q.push_back(8'(i));
    q.push_back(8'd0);
    for (int i = 0; i < N; i++) rd_k[i] = -1;
    k = 0; exp_addr = 0; nfs = 0; nsh = 0;
    first_sh = -1; seen = 0;
    @(posedge clk); #1;
    while (k < 80 && !seen) begin
      start = (k == 0) || (k == rk);
      stall = (k >= slo) && (k <= shi);
      @(negedge clk);
      total++;
      if (busy !== (k >= 1)) begin
        $display("FAIL %s busy k=%0d: got %b want %b",
                 nm, k, busy, (k >= 1));
      end else pass++;
      if (frame_start) begin
        nfs++;
        total++;
        if (k != 1)
          $display("FAIL %s frame_start cycle: got %0d want 1", nm, k);
        else pass++;
      end
      if (mem_rd_en) begin
        total++;
        if (exp_addr >= N || mem_addr !== 4'(exp_addr)) begin
          $display("FAIL %s mem_addr: got %0d want %0d",
                   nm, mem_addr, exp_addr);
        end else pass++;
        if (exp_addr < N) rd_k[exp_addr] = k;
        exp_addr++;
      end
      if (shift) begin
        nsh++;
        if (first_sh < 0) first_sh = k;
        total++;
        if (q.size() == 0) begin
          $display("FAIL %s extra shift: got %0d want none", nm, nsh);
        end else begin
          ex = q.pop_front();
          if (sr_in !== ex)
            $display("FAIL %s sr_in: got %0d want %0d", nm, sr_in, ex);
          else pass++;
        end
      end else begin
        total++;
        if (sr_in !== 8'd0)
          $display("FAIL %s sr_in idle: got %0d want 0", nm, sr_in);
        else pass++;
      end
      if (done) begin
        seen = 1;
        total++;
        if (k != exp_done)
          $display("FAIL %s done cycle: got %0d want %0d",
                   nm, k, exp_done);
        else pass++;
      end
      if (!seen) begin
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    total++;
    if (!seen) $display("FAIL %s timeout: got no done want done", nm);
    else pass++;
    total++;
    if (nfs != 1) $display("FAIL %s frame_starts: got %0d want 1", nm, nfs);
    else pass++;
    total++;
    if (nsh != N + 1) $display("FAIL %s shifts: got %0d want %0d", nm, nsh, N + 1);
    else pass++;
    total++;
    if (exp_addr != N) $display("FAIL %s reads: got %0d want %0d", nm, exp_addr, N);
    else pass++;
    if (slo > 3) begin
      total++;
      if (first_sh != 3)
        $display("FAIL %s first shift: got %0d want 3", nm, first_sh);
      else pass++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s after done: got busy=%b done=%b want 0 0", nm, busy, done);
    else pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({mem_rd_en, shift, frame_start, busy, done} !== 5'b0 ||
        sr_in !== 8'd0 || mem_addr !== 4'd0)
      $display("FAIL reset outputs: got %b %0d %0d want 0 0 0",
               {mem_rd_en, shift, frame_start, busy, done}, sr_in, mem_addr);
    else pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame("basic", 99, -1, -1, 16 + GX);
    total++;
    if (rd_k[4] - rd_k[3] != 1 + GAP || rd_k[8] - rd_k[7] != 1 + GAP)
      $display("FAIL row gap: got %0d %0d want %0d",
               rd_k[4] - rd_k[3], rd_k[8] - rd_k[7], 1 + GAP);
    else pass++;
    total++;
    if (rd_k[11] - rd_k[10] != 1 || rd_k[2] - rd_k[1] != 1)
      $display("FAIL inrow spacing: got %0d %0d want 1 1",
               rd_k[11] - rd_k[10], rd_k[2] - rd_k[1]);
    else pass++;
  endtask

  task automatic test_stall();
    run_frame("stall", 5, 7, -1, 19 + GX);
    total++;
    if (rd_k[3] - rd_k[2] != 4)
      $display("FAIL stall pause: got %0d want 4", rd_k[3] - rd_k[2]);
    else pass++;
  endtask

  task automatic test_restart();
    run_frame("restart", 99, -1, 8, 16 + GX);
  endtask

  task automatic test_tail_stall();
    run_frame("tail_stall", 14 + GX, 999, -1, 16 + GX);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    total++;
    if (mem_rd_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid pre-rst: got rd=%b busy=%b want 1 1", mem_rd_en, busy);
    else pass++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_rd_en, shift, frame_start, busy, done} !== 5'b0 ||
        sr_in !== 8'd0 || mem_addr !== 4'd0)
      $display("FAIL async reset: got %b %0d %0d want 0 0 0",
               {mem_rd_en, shift, frame_start, busy, done}, sr_in, mem_addr);
    else pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || shift !== 1'b0 || mem_rd_en !== 1'b0)
        $display("FAIL no resume: got busy=%b shift=%b rd=%b want 0 0 0",
                 busy, shift, mem_rd_en);
      else pass++;
    end
    run_frame("after_rst", 99, -1, -1, 16 + GX);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_reset_mid();
    test_tail_stall();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
